fpu8_issue_seq: RTL and testbench

- Sequential issue and result-capture stage that sits directly upstream of the combinational 8-bit FPU (FPU_8).
- Accepts operation requests over a valid/ready handshake and registers operands onto the FPU input bus.
- Holds FP_Start for a fixed settle window, then captures OP_RESULT and the exception outputs into a small result FIFO.
- Keeps per-code sticky exception flags for software or the top-level controller.

---
 rtl/fpu8_issue_seq.sv | 203 ++++++++++++++++++++
 tb/tb_fpu8_issue_seq.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu8_issue_seq.sv
`default_nettype none
// ============================================================================
// Module   : fpu8_issue_seq
// Purpose  : Issue / result-capture stage in front of the combinational 8-bit
//            FPU. Accepts requests over valid/ready, registers operands onto
//            the FPU input bus, holds FP_Start for SETTLE_CYCLES, then captures
//            the FPU result and exception outputs into a small result FIFO.
//            Keeps one sticky flag per exception code.
// Ports    :
//   FP_CLK / FP_RST_N          clock, asynchronous active-low reset
//   REQ_VALID/READY/A/B/OP/RND/TAG   request channel
//   FP_Start, OP_A, OP_B, FP_OPERATION, FP_ROUND_MODE   FPU input bus
//   OP_RESULT, OP_IS_EXCEPTION, FP_Exception            FPU outputs
//   RSP_VALID/READY/RESULT/EXC/EXC_CODE/TAG             response (FIFO head)
//   STICKY_EXC / STICKY_CLR    sticky exception flags and their clear
//   BUSY                       high while an op is being driven
//   RES_COUNT                  result FIFO occupancy
// Revision : 1.0 - initial release
// ============================================================================
module fpu8_issue_seq #(
  parameter int SETTLE_CYCLES = 2,
  parameter int RES_DEPTH     = 4,
  parameter int TAG_W         = 2
) (
  input  logic                         FP_CLK,
  input  logic                         FP_RST_N,
  input  logic                         REQ_VALID,
  output logic                         REQ_READY,
  input  logic [7:0]                   REQ_A,
  input  logic [7:0]                   REQ_B,
  input  logic [1:0]                   REQ_OP,
  input  logic                         REQ_RND,
  input  logic [TAG_W-1:0]             REQ_TAG,
  output logic                         FP_Start,
  output logic [7:0]                   OP_A,
  output logic [7:0]                   OP_B,
  output logic [1:0]                   FP_OPERATION,
  output logic                         FP_ROUND_MODE,
  input  logic [7:0]                   OP_RESULT,
  input  logic                         OP_IS_EXCEPTION,
  input  logic [1:0]                   FP_Exception,
  output logic                         RSP_VALID,
  input  logic                         RSP_READY,
  output logic [7:0]                   RSP_RESULT,
  output logic                         RSP_EXC,
  output logic [1:0]                   RSP_EXC_CODE,
  output logic [TAG_W-1:0]             RSP_TAG,
  output logic [3:0]                   STICKY_EXC,
  input  logic                         STICKY_CLR,
  output logic                         BUSY,
  output logic [$clog2(RES_DEPTH):0]   RES_COUNT
);

  localparam int c_ptr_w = $clog2(RES_DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(RES_DEPTH);
  localparam logic [3:0] c_settle_load = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_DRIVE = 1'b1
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [3:0]         r_settle;
  logic [TAG_W-1:0]   r_tag;
  logic               w_accept;
  logic               w_capture;
  logic               w_pop;
  logic [3:0]         w_sticky_set;

  logic [7:0]         r_mem_res  [RES_DEPTH];
  logic               r_mem_exc  [RES_DEPTH];
  logic [1:0]         r_mem_code [RES_DEPTH];
  logic [TAG_W-1:0]   r_mem_tag  [RES_DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;
  logic [3:0]         r_sticky;

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge FP_CLK or negedge FP_RST_N) begin
    if (!FP_RST_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_capture    = 1'b0;
    REQ_READY    = 1'b0;
    case (r_state)
      S_IDLE: begin
        // A free slot is reserved at accept, so the capture can never overflow.
        REQ_READY = (r_count < c_depth);
        if (REQ_VALID && REQ_READY) begin
          w_accept     = 1'b1;
          w_next_state = S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (r_settle == 4'd0) begin
          w_capture    = 1'b1;
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  assign FP_Start = (r_state == S_DRIVE);
  assign BUSY     = (r_state == S_DRIVE);

  // --------------------------------------------------------------------------
  // Operand registers, tag latch and settle counter
  // --------------------------------------------------------------------------
  always_ff @(posedge FP_CLK or negedge FP_RST_N) begin
    if (!FP_RST_N) begin
      OP_A          <= 8'h00;
      OP_B          <= 8'h00;
      FP_OPERATION  <= 2'b00;
      FP_ROUND_MODE <= 1'b0;
      r_tag         <= '0;
      r_settle      <= 4'd0;
    end else if (w_accept) begin
      OP_A          <= REQ_A;
      OP_B          <= REQ_B;
      FP_OPERATION  <= REQ_OP;
      FP_ROUND_MODE <= REQ_RND;
      r_tag         <= REQ_TAG;
      r_settle      <= c_settle_load;
    end else if (r_state == S_DRIVE && r_settle != 4'd0) begin
      r_settle      <= r_settle - 4'd1;
    end
  end

  // --------------------------------------------------------------------------
  // Result FIFO
  // --------------------------------------------------------------------------
  assign w_pop = (r_count != '0) && RSP_READY;

  always_ff @(posedge FP_CLK or negedge FP_RST_N) begin
    if (!FP_RST_N) begin
      for (int i = 0; i < RES_DEPTH; i++) begin
        r_mem_res[i]  <= 8'h00;
        r_mem_exc[i]  <= 1'b0;
        r_mem_code[i] <= 2'b00;
        r_mem_tag[i]  <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_capture) begin
        r_mem_res[r_wr_ptr]  <= OP_RESULT;
        r_mem_exc[r_wr_ptr]  <= OP_IS_EXCEPTION;
        // The code is meaningless without the exception flag; store it masked.
        r_mem_code[r_wr_ptr] <= OP_IS_EXCEPTION ? FP_Exception : 2'b00;
        r_mem_tag[r_wr_ptr]  <= r_tag;
        r_wr_ptr             <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_capture, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign RSP_VALID    = (r_count != '0);
  assign RSP_RESULT   = r_mem_res[r_rd_ptr];
  assign RSP_EXC      = r_mem_exc[r_rd_ptr];
  assign RSP_EXC_CODE = r_mem_code[r_rd_ptr];
  assign RSP_TAG      = r_mem_tag[r_rd_ptr];
  assign RES_COUNT    = r_count;

  // --------------------------------------------------------------------------
  // Sticky exception flags: a set on the same edge as a clear survives.
  // --------------------------------------------------------------------------
  assign w_sticky_set = (w_capture && OP_IS_EXCEPTION) ? (4'b0001 << FP_Exception) : 4'b0000;

  always_ff @(posedge FP_CLK or negedge FP_RST_N) begin
    if (!FP_RST_N) begin
      r_sticky <= 4'b0000;
    end else begin
      r_sticky <= (STICKY_CLR ? 4'b0000 : r_sticky) | w_sticky_set;
    end
  end

  assign STICKY_EXC = r_sticky;

endmodule
`default_nettype wire

// File: tb/tb_fpu8_issue_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpu8_issue_seq
// Purpose  : Self-checking bench for fpu8_issue_seq. A mock FPU supplies the
//            result/exception values chosen per request; a queue of expected
//            responses plus an expected sticky vector form the reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fpu8_issue_seq;

  localparam int S     = 2;
  localparam int DEPTH = 4;
  localparam int TW    = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          REQ_VALID = 1'b0;
  logic          REQ_READY;
  logic [7:0]    REQ_A = 8'h00, REQ_B = 8'h00;
  logic [1:0]    REQ_OP = 2'b00;
  logic          REQ_RND = 1'b0;
  logic [TW-1:0] REQ_TAG = '0;
  logic          FP_Start;
  logic [7:0]    OP_A, OP_B;
  logic [1:0]    FP_OPERATION;
  logic          FP_ROUND_MODE;
  logic [7:0]    OP_RESULT = 8'h00;
  logic          OP_IS_EXCEPTION = 1'b0;
  logic [1:0]    FP_Exception = 2'b00;
  logic          RSP_VALID;
  logic          RSP_READY = 1'b0;
  logic [7:0]    RSP_RESULT;
  logic          RSP_EXC;
  logic [1:0]    RSP_EXC_CODE;
  logic [TW-1:0] RSP_TAG;
  logic [3:0]    STICKY_EXC;
  logic          STICKY_CLR = 1'b0;
  logic          BUSY;
  logic [CW-1:0] RES_COUNT;

  fpu8_issue_seq #(.SETTLE_CYCLES(S), .RES_DEPTH(DEPTH), .TAG_W(TW)) dut (
    .FP_CLK(clk), .FP_RST_N(rst_n),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_A(REQ_A), .REQ_B(REQ_B), .REQ_OP(REQ_OP), .REQ_RND(REQ_RND), .REQ_TAG(REQ_TAG),
    .FP_Start(FP_Start), .OP_A(OP_A), .OP_B(OP_B),
    .FP_OPERATION(FP_OPERATION), .FP_ROUND_MODE(FP_ROUND_MODE),
    .OP_RESULT(OP_RESULT), .OP_IS_EXCEPTION(OP_IS_EXCEPTION), .FP_Exception(FP_Exception),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_RESULT(RSP_RESULT),
    .RSP_EXC(RSP_EXC), .RSP_EXC_CODE(RSP_EXC_CODE), .RSP_TAG(RSP_TAG),
    .STICKY_EXC(STICKY_EXC), .STICKY_CLR(STICKY_CLR),
    .BUSY(BUSY), .RES_COUNT(RES_COUNT)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]    res;
    logic          exc;
    logic [1:0]    code;
    logic [TW-1:0] tag;
  } rsp_t;

  rsp_t       exp_q[$];
  logic [3:0] exp_sticky = 4'b0000;

  // Stimulus only: present a request from a negedge, wait (bounded) for it to
  // be accepted, then program the mock FPU with the values it will return.
  task automatic do_issue(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                          input logic rnd, input logic [TW-1:0] tag, input logic [7:0] res,
                          input logic exc, input logic [1:0] code, output bit ok);
    int   n;
    rsp_t e;
    n  = 0;
    ok = 1'b0;
    REQ_A = a; REQ_B = b; REQ_OP = op; REQ_RND = rnd; REQ_TAG = tag; REQ_VALID = 1'b1;
    while (!ok && n < 50) begin
      if (REQ_READY === 1'b1) begin
        @(posedge clk);
        ok = 1'b1;
      end else begin
        @(negedge clk);
        n++;
      end
    end
    #1;
    REQ_VALID = 1'b0;
    if (ok) begin
      OP_RESULT = res; OP_IS_EXCEPTION = exc; FP_Exception = code;
      e.res = res; e.exc = exc; e.code = exc ? code : 2'b00; e.tag = tag;
      exp_q.push_back(e);
      if (exc) exp_sticky[code] = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic pop_one();
    RSP_READY = 1'b1;
    @(posedge clk);
    #1;
    RSP_READY = 1'b0;
    void'(exp_q.pop_front());
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({FP_Start, BUSY, RSP_VALID, RES_COUNT, STICKY_EXC, OP_A, OP_B, FP_OPERATION, FP_ROUND_MODE} !== '0) begin
      errors++;
      $display("FAIL reset_state: got start=%b busy=%b rv=%b cnt=%0d sticky=%b a=%h b=%h op=%b rnd=%b, expected all 0",
               FP_Start, BUSY, RSP_VALID, RES_COUNT, STICKY_EXC, OP_A, OP_B, FP_OPERATION, FP_ROUND_MODE);
    end
    checks++;
    if ({RSP_RESULT, RSP_EXC, RSP_EXC_CODE, RSP_TAG} !== '0) begin
      errors++;
      $display("FAIL reset_rsp_data: got res=%h exc=%b code=%0d tag=%0d, expected 0", RSP_RESULT, RSP_EXC, RSP_EXC_CODE, RSP_TAG);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (REQ_READY !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b expected 1", REQ_READY);
    end
  endtask

  task automatic test_basic();
    bit ok;
    do_issue(8'h38, 8'h38, 2'b00, 1'b0, 2'd1, 8'h40, 1'b0, 2'b00, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_accept: got timeout expected accept"); end
    REQ_A = 8'hFF; REQ_B = 8'h11;  // must not disturb the op in flight
    for (int i = 0; i < S; i++) begin
      checks++;
      if ({FP_Start, BUSY, REQ_READY, RSP_VALID, OP_A, OP_B} !== {1'b1, 1'b1, 1'b0, 1'b0, 8'h38, 8'h38}) begin
        errors++;
        $display("FAIL basic_drive[%0d]: got start=%b busy=%b rdy=%b rv=%b a=%h b=%h expected 1 1 0 0 38 38",
                 i, FP_Start, BUSY, REQ_READY, RSP_VALID, OP_A, OP_B);
      end
      @(negedge clk);
    end
    checks++;
    if ({FP_Start, RSP_VALID, RSP_RESULT, RSP_TAG, RSP_EXC, REQ_READY} !== {1'b0, 1'b1, 8'h40, 2'd1, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL basic_capture: got start=%b rv=%b res=%h tag=%0d exc=%b rdy=%b expected 0 1 40 1 0 1",
               FP_Start, RSP_VALID, RSP_RESULT, RSP_TAG, RSP_EXC, REQ_READY);
    end
    checks++;
    if (OP_A !== 8'h38) begin errors++; $display("FAIL basic_hold_opa: got %h expected 38", OP_A); end
    pop_one();
    checks++;
    if (RSP_VALID !== 1'b0) begin errors++; $display("FAIL basic_empty: got %b expected 0", RSP_VALID); end
  endtask

  task automatic test_backpressure();
    bit   ok;
    rsp_t e;
    int   n;
    RSP_READY = 1'b0;
    for (int i = 0; i < 4; i++) begin
      do_issue(8'($urandom), 8'($urandom), 2'($urandom), 1'($urandom), TW'(i), 8'($urandom),
               1'b0, 2'($urandom), ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL bp_accept[%0d]: got timeout expected accept", i); end
    end
    repeat (S) @(negedge clk);
    REQ_A = 8'h5A; REQ_TAG = 2'd0; REQ_VALID = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({RES_COUNT, REQ_READY, BUSY} !== {CW'(4), 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL bp_full: got cnt=%0d rdy=%b busy=%b expected 4 0 0", RES_COUNT, REQ_READY, BUSY);
    end
    e = exp_q[0];
    checks++;
    if ({RSP_RESULT, RSP_EXC, RSP_EXC_CODE, RSP_TAG} !== {e.res, e.exc, e.code, e.tag}) begin
      errors++;
      $display("FAIL bp_head: got %h/%b/%0d/%0d expected %h/%b/%0d/%0d", RSP_RESULT, RSP_EXC, RSP_EXC_CODE, RSP_TAG,
               e.res, e.exc, e.code, e.tag);
    end
    pop_one();
    checks++;
    if (REQ_READY !== 1'b1) begin errors++; $display("FAIL bp_ready_after_pop: got %b expected 1", REQ_READY); end
    do_issue(8'h5A, 8'hA5, 2'b11, 1'b1, 2'd0, 8'hC3, 1'b0, 2'b00, ok);
    checks++;
    if (!ok || BUSY !== 1'b1) begin errors++; $display("FAIL bp_fifth_accept: got ok=%b busy=%b expected 1 1", ok, BUSY); end
    repeat (S) @(negedge clk);
    n = 0;
    while (exp_q.size() > 0 && n < 10) begin
      e = exp_q[0];
      checks++;
      if ({RSP_VALID, RSP_RESULT, RSP_EXC, RSP_EXC_CODE, RSP_TAG} !== {1'b1, e.res, e.exc, e.code, e.tag}) begin
        errors++;
        $display("FAIL bp_drain[%0d]: got v=%b %h/%b/%0d/%0d expected 1 %h/%b/%0d/%0d", n, RSP_VALID, RSP_RESULT,
                 RSP_EXC, RSP_EXC_CODE, RSP_TAG, e.res, e.exc, e.code, e.tag);
      end
      pop_one();
      n++;
    end
  endtask

  task automatic test_exceptions();
    bit ok;
    do_issue(8'h7F, 8'h7F, 2'b10, 1'b0, 2'd2, 8'h7C, 1'b1, 2'b10, ok);
    repeat (S) @(negedge clk);
    checks++;
    if ({ok, RSP_EXC, RSP_EXC_CODE, STICKY_EXC} !== {1'b1, 1'b1, 2'd2, 4'b0100}) begin
      errors++;
      $display("FAIL exc_capture: got ok=%b exc=%b code=%0d sticky=%b expected 1 1 2 0100", ok, RSP_EXC, RSP_EXC_CODE, STICKY_EXC);
    end
    // Exception flag low: code must be masked and must not touch the sticky bits.
    do_issue(8'h01, 8'h02, 2'b01, 1'b1, 2'd3, 8'h21, 1'b0, 2'b11, ok);
    repeat (S) @(negedge clk);
    pop_one();
    checks++;
    if ({RSP_TAG, RSP_EXC, RSP_EXC_CODE, RSP_RESULT, STICKY_EXC} !== {2'd3, 1'b0, 2'd0, 8'h21, exp_sticky}) begin
      errors++;
      $display("FAIL exc_masked: got tag=%0d exc=%b code=%0d res=%h sticky=%b expected 3 0 0 21 %b",
               RSP_TAG, RSP_EXC, RSP_EXC_CODE, RSP_RESULT, STICKY_EXC, exp_sticky);
    end
    pop_one();
    // Clear coincides with a code-1 capture.
    do_issue(8'h10, 8'h20, 2'b00, 1'b0, 2'd0, 8'h99, 1'b1, 2'b01, ok);
    repeat (S - 1) @(negedge clk);
    STICKY_CLR = 1'b1;
    @(posedge clk);
    #1;
    STICKY_CLR = 1'b0;
    exp_sticky = 4'b0010;
    @(negedge clk);
    checks++;
    if ({STICKY_EXC, RSP_EXC_CODE} !== {exp_sticky, 2'd1}) begin
      errors++;
      $display("FAIL exc_clear_race: got sticky=%b code=%0d expected %b 1", STICKY_EXC, RSP_EXC_CODE, exp_sticky);
    end
    pop_one();
    STICKY_CLR = 1'b1;
    @(negedge clk);
    STICKY_CLR = 1'b0;
    exp_sticky = 4'b0000;
    checks++;
    if (STICKY_EXC !== exp_sticky) begin errors++; $display("FAIL exc_clear: got %b expected 0000", STICKY_EXC); end
  endtask

  task automatic test_push_pop();
    bit   ok;
    rsp_t e;
    do_issue(8'h31, 8'h32, 2'b01, 1'b0, 2'd1, 8'hAA, 1'b0, 2'b00, ok);
    repeat (S) @(negedge clk);
    do_issue(8'h41, 8'h42, 2'b10, 1'b1, 2'd2, 8'hBB, 1'b1, 2'b00, ok);
    repeat (S - 1) @(negedge clk);
    checks++;
    if ({RES_COUNT, RSP_TAG} !== {CW'(1), 2'd1}) begin
      errors++;
      $display("FAIL pp_before: got cnt=%0d tag=%0d expected 1 1", RES_COUNT, RSP_TAG);
    end
    pop_one();  // this pop shares its edge with the capture
    e = exp_q[0];
    checks++;
    if ({RES_COUNT, RSP_RESULT, RSP_TAG, RSP_EXC} !== {CW'(1), e.res, e.tag, e.exc}) begin
      errors++;
      $display("FAIL pp_after: got cnt=%0d res=%h tag=%0d exc=%b expected 1 %h %0d %b",
               RES_COUNT, RSP_RESULT, RSP_TAG, RSP_EXC, e.res, e.tag, e.exc);
    end
    pop_one();
    STICKY_CLR = 1'b1;
    @(negedge clk);
    STICKY_CLR = 1'b0;
    exp_sticky = 4'b0000;
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_issue(8'h01, 8'h01, 2'b00, 1'b0, 2'd1, 8'h11, 1'b1, 2'b11, ok);
    repeat (S) @(negedge clk);
    do_issue(8'h02, 8'h02, 2'b00, 1'b0, 2'd2, 8'h22, 1'b0, 2'b00, ok);
    repeat (S) @(negedge clk);
    do_issue(8'h03, 8'h03, 2'b00, 1'b0, 2'd3, 8'h33, 1'b0, 2'b00, ok);
    checks++;
    if ({BUSY, RES_COUNT, STICKY_EXC} !== {1'b1, CW'(2), 4'b1000}) begin
      errors++;
      $display("FAIL rm_setup: got busy=%b cnt=%0d sticky=%b expected 1 2 1000", BUSY, RES_COUNT, STICKY_EXC);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({FP_Start, BUSY, RSP_VALID, RES_COUNT, STICKY_EXC, RSP_RESULT, RSP_TAG} !== '0) begin
      errors++;
      $display("FAIL rm_async: got start=%b busy=%b rv=%b cnt=%0d sticky=%b res=%h tag=%0d expected all 0",
               FP_Start, BUSY, RSP_VALID, RES_COUNT, STICKY_EXC, RSP_RESULT, RSP_TAG);
    end
    exp_q.delete();
    exp_sticky = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if ({REQ_READY, BUSY} !== 2'b10) begin
      errors++;
      $display("FAIL rm_release: got rdy=%b busy=%b expected 1 0", REQ_READY, BUSY);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    bit   ok;
    rsp_t e;
    int   npop;
    for (int i = 0; i < 40; i++) begin
      do_issue(8'($urandom), 8'($urandom), 2'($urandom), 1'($urandom), TW'(i), 8'($urandom),
               1'($urandom_range(0, 3) == 0), 2'($urandom), ok);
      repeat (S) @(negedge clk);
      checks++;
      if (!ok || RES_COUNT !== CW'(exp_q.size()) || STICKY_EXC !== exp_sticky) begin
        errors++;
        $display("FAIL rnd_state[%0d]: got ok=%b cnt=%0d sticky=%b expected 1 %0d %b", i, ok, RES_COUNT, STICKY_EXC,
                 exp_q.size(), exp_sticky);
      end
      npop = $urandom_range(0, exp_q.size());
      if (exp_q.size() == DEPTH && npop == 0) npop = 1;
      for (int k = 0; k < npop; k++) begin
        e = exp_q[0];
        checks++;
        if ({RSP_VALID, RSP_RESULT, RSP_EXC, RSP_EXC_CODE, RSP_TAG} !== {1'b1, e.res, e.exc, e.code, e.tag}) begin
          errors++;
          $display("FAIL rnd_head[%0d.%0d]: got v=%b %h/%b/%0d/%0d expected 1 %h/%b/%0d/%0d", i, k, RSP_VALID,
                   RSP_RESULT, RSP_EXC, RSP_EXC_CODE, RSP_TAG, e.res, e.exc, e.code, e.tag);
        end
        pop_one();
      end
      if ($urandom_range(0, 5) == 0) begin
        STICKY_CLR = 1'b1;
        @(negedge clk);
        STICKY_CLR = 1'b0;
        exp_sticky = 4'b0000;
      end
    end
    while (exp_q.size() > 0) begin
      e = exp_q[0];
      checks++;
      if ({RSP_VALID, RSP_RESULT, RSP_EXC, RSP_EXC_CODE, RSP_TAG} !== {1'b1, e.res, e.exc, e.code, e.tag}) begin
        errors++;
        $display("FAIL rnd_drain: got v=%b %h/%b/%0d/%0d expected 1 %h/%b/%0d/%0d", RSP_VALID,
                 RSP_RESULT, RSP_EXC, RSP_EXC_CODE, RSP_TAG, e.res, e.exc, e.code, e.tag);
      end
      pop_one();
    end
    checks++;
    if ({RSP_VALID, RES_COUNT} !== {1'b0, CW'(0)}) begin
      errors++;
      $display("FAIL rnd_empty: got v=%b cnt=%0d expected 0 0", RSP_VALID, RES_COUNT);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_backpressure();
    test_exceptions();
    test_push_pop();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
